// File: rtl/fir_pkg.sv
// Shared types and arithmetic helpers for the streaming FIR family.
// Rounding and clamping work on a wide signed accumulator image.
package fir_pkg;

    localparam int MAX_W = 64;

    typedef logic signed [MAX_W-1:0] wide_t;

    function automatic int acc_width(
        input int data_w,
        input int coef_w,
        input int taps
    );
        return data_w + coef_w + $clog2(taps);
    endfunction

    // Round half up: add half an LSB of the result, then arithmetic shift.
    function automatic wide_t round_acc(
        input wide_t acc,
        input int    shift
    );
        wide_t r;
        r = acc;
        if (shift > 0) begin
            r = (acc + (wide_t'(1) <<< (shift - 1))) >>> shift;
        end
        return r;
    endfunction

    function automatic wide_t out_max(input int out_w);
        return (wide_t'(1) <<< (out_w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t out_min(input int out_w);
        return -(wide_t'(1) <<< (out_w - 1));
    endfunction

    function automatic wide_t sat_round(
        input wide_t acc,
        input int    shift,
        input int    out_w
    );
        wide_t r;
        r = round_acc(acc, shift);
        if (r > out_max(out_w)) begin
            r = out_max(out_w);
        end else if (r < out_min(out_w)) begin
            r = out_min(out_w);
        end
        return r;
    endfunction

    function automatic logic sat_hit(
        input wide_t acc,
        input int    shift,
        input int    out_w
    );
        wide_t r;
        r = round_acc(acc, shift);
        return (r > out_max(out_w)) || (r < out_min(out_w));
    endfunction

endpackage

// File: rtl/fir_round_sat.sv
// Combinational round-half-up and clamp of an accumulator to OUT_W bits.
// Reusable by any filter that ends in a wide signed accumulator.
module fir_round_sat
    import fir_pkg::*;
#(
    parameter int ACC_W = 18,
    parameter int OUT_W = 16,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output logic signed [OUT_W-1:0] data_o,
    output logic                    sat_o
);

    assign data_o = OUT_W'(sat_round(wide_t'(acc_i), SHIFT, OUT_W));
    assign sat_o  = sat_hit(wide_t'(acc_i), SHIFT, OUT_W);

endmodule

// File: rtl/fir_stream_core.sv
// N-tap direct-form FIR with valid/ready streaming, shadow/active
// coefficient banks with a drained atomic swap, rounding and saturation.
module fir_stream_core
    import fir_pkg::*;
#(
    parameter int TAPS   = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    input  logic                    coef_swap,
    output logic                    swap_done,
    output logic                    sat_flag,
    input  logic                    sat_clr
);

    localparam int ACC_W  = acc_width(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;

    logic signed [DATA_W-1:0] x_q      [TAPS];
    logic signed [DATA_W-1:0] x_d      [TAPS];
    logic signed [COEF_W-1:0] shadow_q [TAPS];
    logic signed [COEF_W-1:0] shadow_d [TAPS];
    logic signed [COEF_W-1:0] act_q    [TAPS];
    logic signed [COEF_W-1:0] act_d    [TAPS];
    logic signed [PROD_W-1:0] p_q      [TAPS];
    logic signed [PROD_W-1:0] p_d      [TAPS];
    logic signed [ACC_W-1:0]  psum     [TAPS+1];

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic signed [OUT_W-1:0] rs_data;

    logic v1_q, v1_d;
    logic v2_q, v2_d;
    logic out_valid_q, out_valid_d;
    logic swap_done_q, swap_done_d;
    logic sat_q, sat_d;
    logic en, accept, do_swap, rs_sat;

    assign psum[0] = '0;

    for (genvar k = 0; k < TAPS; k++) begin : g_add
        assign psum[k+1] = psum[k] + ACC_W'(p_q[k]);
    end

    fir_round_sat #(
        .ACC_W (ACC_W),
        .OUT_W (OUT_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .acc_i  (acc_q),
        .data_o (rs_data),
        .sat_o  (rs_sat)
    );

    always_comb begin
        en      = !out_valid_q || out_ready;
        accept  = in_valid && en && !coef_swap;
        do_swap = coef_swap && en && !v1_q && !v2_q;

        for (int k = 0; k < TAPS; k++) begin
            x_d[k]      = x_q[k];
            shadow_d[k] = shadow_q[k];
            act_d[k]    = act_q[k];
            p_d[k]      = p_q[k];
        end

        if (accept) begin
            x_d[0] = in_data;
            for (int k = 1; k < TAPS; k++) begin
                x_d[k] = x_q[k-1];
            end
        end

        if (coef_we && (int'(coef_addr) < TAPS)) begin
            shadow_d[coef_addr] = coef_data;
        end

        // Copy reads the pre-edge shadow, so a same-edge write lands after it.
        if (do_swap) begin
            for (int k = 0; k < TAPS; k++) begin
                act_d[k] = shadow_q[k];
            end
        end

        v1_d        = v1_q;
        v2_d        = v2_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;

        // Stage 1 multiplies the window that includes the sample accepted now.
        if (en) begin
            for (int k = 0; k < TAPS; k++) begin
                p_d[k] = PROD_W'(act_q[k]) * PROD_W'(x_d[k]);
            end
            v1_d        = accept;
            acc_d       = psum[TAPS];
            v2_d        = v1_q;
            out_data_d  = rs_data;
            out_valid_d = v2_q;
        end

        swap_done_d = do_swap;
        sat_d       = (sat_q && !sat_clr) || (en && v2_q && rs_sat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]      <= '0;
                shadow_q[k] <= '0;
                act_q[k]    <= '0;
                p_q[k]      <= '0;
            end
            acc_q       <= '0;
            out_data_q  <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            swap_done_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            for (int k = 0; k < TAPS; k++) begin
                x_q[k]      <= x_d[k];
                shadow_q[k] <= shadow_d[k];
                act_q[k]    <= act_d[k];
                p_q[k]      <= p_d[k];
            end
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            swap_done_q <= swap_done_d;
            sat_q       <= sat_d;
        end
    end

    assign in_ready  = en && !coef_swap;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign swap_done = swap_done_q;
    assign sat_flag  = sat_q;

endmodule
